// File: rtl/conv_enc_bounded_noise.sv
// conv_enc_bounded_noise: framed rate-1/2 convolutional encoder with zero tail and
// window-budgeted bit-flip injection on the two code outputs.
module conv_enc_bounded_noise #(
  parameter int K = 4,
  parameter logic [K-1:0] G0 = 4'b1101,
  parameter logic [K-1:0] G1 = 4'b1111,
  parameter int WIN = 4,
  parameter int MAX_ERR = 1,
  parameter int FRAME_LEN = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  input  logic       noise0,
  input  logic       noise1,
  output logic       out_valid,
  output logic       out1,
  output logic       out2,
  output logic       noise_drop,
  output logic [7:0] err_count,
  output logic       frame_done
);
  localparam int BW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam int TW = K > 2 ? $clog2(K - 1) : 1;
  localparam logic [BW-1:0] BLAST = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TLAST = TW'(K - 2);
  localparam logic [5:0] ME = 6'(MAX_ERR);

  typedef enum logic {DATA, TAIL} state_t;
  state_t r_state, w_next;

  logic [BW-1:0] r_bit_cnt;
  logic [TW-1:0] r_tail_cnt;
  logic [K-2:0]  r_sr;
  logic [1:0]    r_hist [0:WIN-2];
  logic [K-1:0]  w_u;
  logic [5:0]    w_sum;
  logic [8:0]    w_err;
  logic          w_step, w_cur, w_g0, w_g1, w_last;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIN - 1; i++) w_sum = w_sum + {4'b0, r_hist[i]};
  end

  assign in_ready = r_state == DATA;
  assign w_step   = r_state == TAIL || in_valid;
  assign w_cur    = in_ready & in_bit;
  assign w_u      = {w_cur, r_sr};
  // noise0 takes budget first; noise1 sees what is left after it
  assign w_g0     = w_step && noise0 && w_sum < ME;
  assign w_g1     = w_step && noise1 && (w_sum + {5'b0, w_g0}) < ME;
  assign w_last   = r_state == DATA ? r_bit_cnt == BLAST : r_tail_cnt == TLAST;
  assign w_err    = {1'b0, frame_done ? 8'd0 : err_count} + 9'(w_g0) + 9'(w_g1);

  always_comb w_next = (w_step && w_last) ? (r_state == DATA ? TAIL : DATA) : r_state;

  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) r_state <= DATA;
    else r_state <= w_next;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
      r_sr       <= '0;
      for (int i = 0; i < WIN - 1; i++) r_hist[i] <= '0;
      out_valid  <= 1'b0;
      out1       <= 1'b0;
      out2       <= 1'b0;
      noise_drop <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      out_valid  <= w_step;
      frame_done <= w_step && w_last && r_state == TAIL;
      noise_drop <= (noise0 && w_step && !w_g0) || (noise1 && w_step && !w_g1);
      err_count  <= w_err[8] ? 8'hff : w_err[7:0];
      if (w_step) begin
        out1       <= ^(w_u & G0) ^ w_g0;
        out2       <= ^(w_u & G1) ^ w_g1;
        r_sr       <= w_u[K-1:1];
        r_hist[0]  <= {w_g0 & w_g1, w_g0 ^ w_g1};
        for (int i = 1; i < WIN - 1; i++) r_hist[i] <= r_hist[i-1];
        r_bit_cnt  <= r_state == DATA ? (w_last ? '0 : r_bit_cnt + 1'b1) : r_bit_cnt;
        r_tail_cnt <= r_state == TAIL ? (w_last ? '0 : r_tail_cnt + 1'b1) : r_tail_cnt;
      end
    end
  end
endmodule

// File: tb/tb_conv_enc_bounded_noise.sv
// tb_conv_enc_bounded_noise: three encoder variants on shared stimulus, each with a
// reference-model scoreboard, plus scenario tasks checking fixed expected sequences.
module tb_conv_enc_bounded_noise;
  logic clock = 0, rst_n = 1, in_valid = 0, in_bit = 0, noise0 = 0, noise1 = 0;
  int n_pass = 0, n_total = 0;

  always #5 clock = ~clock;

  typedef struct packed {logic o1; logic o2; logic dr; logic fd; logic [7:0] ec;} sym_t;

  // d[0]: defaults, d[1]: MAX_ERR=2, d[2]: K=3 G0=111 G1=101
  for (genvar g = 0; g < 3; g++) begin : d
    localparam int KK = g == 2 ? 3 : 4;
    localparam int ME = g == 1 ? 2 : 1;
    localparam logic [7:0] GG0 = g == 2 ? 8'h07 : 8'h0d;
    localparam logic [7:0] GG1 = g == 2 ? 8'h05 : 8'h0f;
    logic in_ready, out_valid, out1, out2, noise_drop, frame_done;
    logic [7:0] err_count;

    conv_enc_bounded_noise #(.K(KK), .G0(GG0[KK-1:0]), .G1(GG1[KK-1:0]), .WIN(4),
                             .MAX_ERR(ME), .FRAME_LEN(16)) u_dut (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .noise0(noise0), .noise1(noise1), .out_valid(out_valid),
      .out1(out1), .out2(out2), .noise_drop(noise_drop), .err_count(err_count),
      .frame_done(frame_done));

    sym_t q[$];

    initial begin
      int st, bc, tc, err, sum;
      int hist[3];
      logic [7:0] sr, u;
      logic stp, g0, g1, fd, fdr;
      sym_t s;
      st = 0; bc = 0; tc = 0; err = 0; sr = 0; fdr = 0; hist = '{0, 0, 0};
      forever begin
        @(posedge clock);
        if (!rst_n) begin
          st = 0; bc = 0; tc = 0; err = 0; sr = 0; fdr = 0; hist = '{0, 0, 0};
          q.delete();
        end else begin
          stp = st == 1 || in_valid;
          fd = 0;
          if (fdr) err = 0;
          if (stp) begin
            u = sr | (8'(st == 0 && in_bit) << (KK - 1));
            sum = hist[0] + hist[1] + hist[2];
            g0 = noise0 && sum < ME;
            g1 = noise1 && (sum + int'(g0)) < ME;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(g0) + int'(g1);
            sr = u >> 1;
            err = (err + int'(g0) + int'(g1)) > 255 ? 255 : err + int'(g0) + int'(g1);
            if (st == 0) begin
              if (bc == 15) begin st = 1; tc = 0; bc = 0; end
              else bc++;
            end else if (tc == KK - 2) begin st = 0; fd = 1; end
            else tc++;
            s.o1 = ^(u & GG0) ^ g0;
            s.o2 = ^(u & GG1) ^ g1;
            s.dr = (noise0 && !g0) || (noise1 && !g1);
            s.fd = fd;
            s.ec = 8'(err);
            q.push_back(s);
          end
          fdr = fd;
        end
        @(negedge clock);
        if (!rst_n) begin
          st = 0; bc = 0; tc = 0; err = 0; sr = 0; fdr = 0; hist = '{0, 0, 0};
          q.delete();
        end else begin
          n_total++;
          if (in_ready !== (st == 0)) $display("FAIL dut%0d in_ready got %b want %b", g, in_ready, st == 0);
          else n_pass++;
          n_total++;
          if (out_valid !== (q.size() != 0)) $display("FAIL dut%0d out_valid got %b want %b", g, out_valid, q.size() != 0);
          else n_pass++;
          if (out_valid === 1'b1 && q.size() != 0) begin
            s = q.pop_front();
            n_total++;
            if ({out1, out2, noise_drop, frame_done, err_count} !== s)
              $display("FAIL dut%0d symbol {o1,o2,drop,fd,err} got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                       g, out1, out2, noise_drop, frame_done, err_count, s.o1, s.o2, s.dr, s.fd, s.ec);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    in_valid = 0; in_bit = 0; noise0 = 0; noise1 = 0;
    @(posedge clock); #1 rst_n = 0;
    @(posedge clock); #1 rst_n = 1;
  endtask

  task automatic run_impulse(output logic [18:0] a1, a2, output logic [17:0] c1, c2,
                             output int na, nc, fa, fc);
    a1 = 0; a2 = 0; c1 = 0; c2 = 0; na = 0; nc = 0; fa = 0; fc = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clock); #1 in_valid = c < 16; in_bit = c == 0; noise0 = 0; noise1 = 0;
      @(negedge clock);
      if (d[0].out_valid) begin
        a1 = {a1[17:0], d[0].out1}; a2 = {a2[17:0], d[0].out2}; na++;
        if (d[0].frame_done) fa = na;
      end
      if (d[2].out_valid) begin
        c1 = {c1[16:0], d[2].out1}; c2 = {c2[16:0], d[2].out2}; nc++;
        if (d[2].frame_done) fc = nc;
      end
    end
    in_valid = 0; in_bit = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    n_total++;
    if ({d[0].out_valid, d[0].out1, d[0].out2, d[0].noise_drop, d[0].frame_done, d[0].err_count} !== 13'b0)
      $display("FAIL reset_outputs got %b want 0", {d[0].out_valid, d[0].out1, d[0].out2,
               d[0].noise_drop, d[0].frame_done, d[0].err_count});
    else n_pass++;
    n_total++;
    if (d[0].in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", d[0].in_ready);
    else n_pass++;
    @(posedge clock); #1 rst_n = 1;
  endtask

  task automatic test_impulse();
    logic [18:0] a1, a2; logic [17:0] c1, c2; int na, nc, fa, fc;
    apply_reset();
    run_impulse(a1, a2, c1, c2, na, nc, fa, fc);
    n_total++; if (a1 !== {4'b1101, 15'b0}) $display("FAIL impulse_out1 got %b want %b", a1, {4'b1101, 15'b0}); else n_pass++;
    n_total++; if (a2 !== {4'b1111, 15'b0}) $display("FAIL impulse_out2 got %b want %b", a2, {4'b1111, 15'b0}); else n_pass++;
    n_total++; if (na != 19) $display("FAIL impulse_symbols got %0d want 19", na); else n_pass++;
    n_total++; if (fa != 19) $display("FAIL impulse_frame_done got %0d want 19", fa); else n_pass++;
  endtask

  task automatic test_param_k3();
    logic [18:0] a1, a2; logic [17:0] c1, c2; int na, nc, fa, fc;
    apply_reset();
    run_impulse(a1, a2, c1, c2, na, nc, fa, fc);
    n_total++; if (c1 !== {3'b111, 15'b0}) $display("FAIL k3_out1 got %b want %b", c1, {3'b111, 15'b0}); else n_pass++;
    n_total++; if (c2 !== {3'b101, 15'b0}) $display("FAIL k3_out2 got %b want %b", c2, {3'b101, 15'b0}); else n_pass++;
    n_total++; if (nc != 18) $display("FAIL k3_symbols got %0d want 18", nc); else n_pass++;
    n_total++; if (fc != 18) $display("FAIL k3_frame_done got %0d want 18", fc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [56:0] ra, rc, ea, ec; int gapa, gapc;
    gapa = 0; gapc = 0;
    apply_reset();
    for (int c = 0; c < 57; c++) begin
      @(posedge clock); #1 in_valid = 1; in_bit = 1'($urandom);
      noise0 = $urandom_range(0, 3) == 0; noise1 = $urandom_range(0, 3) == 0;
      @(negedge clock);
      ra[c] = d[0].in_ready; rc[c] = d[2].in_ready;
      ea[c] = (c % 19) < 16; ec[c] = (c % 18) < 16;
      if (c >= 1 && d[0].out_valid !== 1'b1) gapa++;
      if (c >= 1 && d[2].out_valid !== 1'b1) gapc++;
    end
    in_valid = 0; noise0 = 0; noise1 = 0;
    n_total++; if (ra !== ea) $display("FAIL b2b_ready_k4 got %b want %b", ra, ea); else n_pass++;
    n_total++; if (rc !== ec) $display("FAIL b2b_ready_k3 got %b want %b", rc, ec); else n_pass++;
    n_total++; if (gapa != 0) $display("FAIL b2b_valid_gaps_k4 got %0d want 0", gapa); else n_pass++;
    n_total++; if (gapc != 0) $display("FAIL b2b_valid_gaps_k3 got %0d want 0", gapc); else n_pass++;
  endtask

  task automatic test_window();
    logic [31:0] wa1, wad, wb1, wbd, xa, xb; int na, nb, nf; logic [7:0] fe1, fe2, e19;
    na = 0; nb = 0; nf = 0; fe1 = 0; fe2 = 0; e19 = 8'hxx;
    wa1 = 0; wad = 0; wb1 = 0; wbd = 0;
    apply_reset();
    for (int c = 0; c < 42; c++) begin
      @(posedge clock); #1 in_valid = 1; in_bit = 0; noise0 = 1; noise1 = 0;
      @(negedge clock);
      if (d[0].out_valid) begin
        if (na < 32) begin wa1[na] = d[0].out1; wad[na] = d[0].noise_drop; end
        if (na == 19) e19 = d[0].err_count;
        if (d[0].frame_done) begin
          if (nf == 0) fe1 = d[0].err_count; else fe2 = d[0].err_count;
          nf++;
        end
        na++;
      end
      if (d[1].out_valid) begin
        if (nb < 32) begin wb1[nb] = d[1].out1; wbd[nb] = d[1].noise_drop; end
        nb++;
      end
    end
    in_valid = 0; noise0 = 0;
    for (int i = 0; i < 32; i++) begin xa[i] = i % 4 == 0; xb[i] = i % 4 < 2; end
    n_total++; if (wa1 !== xa) $display("FAIL window_flips_me1 got %b want %b", wa1, xa); else n_pass++;
    n_total++; if (wad !== ~xa) $display("FAIL window_drops_me1 got %b want %b", wad, ~xa); else n_pass++;
    n_total++; if (wb1 !== xb) $display("FAIL window_flips_me2 got %b want %b", wb1, xb); else n_pass++;
    n_total++; if (wbd !== ~xb) $display("FAIL window_drops_me2 got %b want %b", wbd, ~xb); else n_pass++;
    n_total++; if (fe1 !== 8'd5) $display("FAIL err_frame1 got %0d want 5", fe1); else n_pass++;
    n_total++; if (fe2 !== 8'd5) $display("FAIL err_frame2 got %0d want 5", fe2); else n_pass++;
    n_total++; if (e19 !== 8'd0) $display("FAIL err_cleared got %0d want 0", e19); else n_pass++;
  endtask

  task automatic test_dual();
    logic [10:0] b0, b1, a0;
    apply_reset();
    @(posedge clock); #1 in_valid = 1; in_bit = 0; noise0 = 1; noise1 = 1;
    @(posedge clock); #1;
    @(negedge clock);
    b0 = {d[1].out1, d[1].out2, d[1].noise_drop, d[1].err_count};
    a0 = {d[0].out1, d[0].out2, d[0].noise_drop, d[0].err_count};
    @(posedge clock); #1 noise0 = 0; noise1 = 0; in_valid = 0;
    @(negedge clock);
    b1 = {d[1].out1, d[1].out2, d[1].noise_drop, d[1].err_count};
    n_total++; if (b0 !== {3'b110, 8'd2}) $display("FAIL dual_grant got %b want %b", b0, {3'b110, 8'd2}); else n_pass++;
    n_total++; if (b1 !== {3'b001, 8'd2}) $display("FAIL dual_repeat_drop got %b want %b", b1, {3'b001, 8'd2}); else n_pass++;
    n_total++; if (a0 !== {3'b101, 8'd1}) $display("FAIL dual_priority_me1 got %b want %b", a0, {3'b101, 8'd1}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [18:0] a1, a2; logic [17:0] c1, c2; int na, nc, fa, fc;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1 in_valid = 1; in_bit = 1; noise0 = c == 0; noise1 = 0;
    end
    @(posedge clock); #1 rst_n = 0;
    #1;
    n_total++;
    if ({d[0].out_valid, d[0].out1, d[0].out2, d[0].noise_drop, d[0].frame_done, d[0].err_count} !== 13'b0)
      $display("FAIL midreset_outputs got %b want 0", {d[0].out_valid, d[0].out1, d[0].out2,
               d[0].noise_drop, d[0].frame_done, d[0].err_count});
    else n_pass++;
    n_total++; if (d[0].in_ready !== 1'b1) $display("FAIL midreset_in_ready got %b want 1", d[0].in_ready); else n_pass++;
    in_valid = 0; in_bit = 0; noise0 = 0;
    @(posedge clock); #1 rst_n = 1;
    run_impulse(a1, a2, c1, c2, na, nc, fa, fc);
    n_total++; if (a1 !== {4'b1101, 15'b0}) $display("FAIL midreset_out1 got %b want %b", a1, {4'b1101, 15'b0}); else n_pass++;
    n_total++; if (a2 !== {4'b1111, 15'b0}) $display("FAIL midreset_out2 got %b want %b", a2, {4'b1111, 15'b0}); else n_pass++;
    n_total++; if (na != 19) $display("FAIL midreset_symbols got %0d want 19", na); else n_pass++;
    n_total++; if (fa != 19) $display("FAIL midreset_frame_done got %0d want 19", fa); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back();
    test_window();
    test_dual();
    test_reset_mid();
    test_param_k3();
    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/conv_enc_bounded_noise.md
Name: conv_enc_bounded_noise

Overview:
Parametrised rate-1/2 feed-forward convolutional encoder with a bounded-error channel model, for equivalence and compositional decoder-synthesis test benches. It encodes framed input bits and appends K-1 zero tail bits per frame. Externally requested bit flips are injected on the two code outputs, but only while a sliding-window error budget holds. It is the generalised successor to the fixed K=4 encoder/noise cell: constraint length, polynomials, window, budget and frame length are configurable, and it adds a valid/ready handshake, frame termination and error accounting.

Parameters:
K, 4, constraint length (K-1 memory bits), legal 2..8
G0, 4'b1101, generator polynomial for out1, width K
G1, 4'b1111, generator polynomial for out2, width K
WIN, 4, sliding error window in encoder steps, legal 2..16
MAX_ERR, 1, maximum injected bit errors within any WIN consecutive steps, legal 1..2*WIN
FRAME_LEN, 16, data bits per frame, legal >=1

Ports:
clock  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  in_bit is offered this cycle
in_bit  in  1  data bit
in_ready  out  1  block accepts in_bit this cycle
noise0  in  1  request flip of out1 for this step
noise1  in  1  request flip of out2 for this step
out_valid  out  1  out1/out2 carry a code symbol
out1  out  1  code bit from G0, possibly flipped
out2  out  1  code bit from G1, possibly flipped
noise_drop  out  1  a flip request was suppressed this step
err_count  out  8  bits flipped in current frame, saturating at 255
frame_done  out  1  one-cycle pulse after last tail symbol

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. It clears the shift register, bit counter, tail counter, window history, err_count, out_valid, out1, out2, noise_drop and frame_done to 0, and sets the state to DATA. Reset mid-frame aborts the frame; no tail is emitted.
- States:
  - DATA: in_ready=1. An accept is in_valid & in_ready, and each accept is one encoder step. After the FRAME_LEN-th accept, go to TAIL.
  - TAIL: in_ready=0. Each cycle is one encoder step with input bit 0, for K-1 cycles. After the last tail step, go to DATA. frame_done pulses in the cycle the last tail symbol is on the outputs.
- Encoder step:
  - u = {cur_bit, sr[K-2:0]}, where u[K-1] is the current bit and u[0] is the oldest bit.
  - c0 = XOR-reduce(u & G0); c1 = XOR-reduce(u & G1).
  - sr shifts the current bit in at the top.
- Outputs are registered. Latency is 1: the step taken at edge n appears at edge n+1 with out_valid=1. out_valid=0 on non-step cycles; out1 and out2 then hold their last values.
- Noise gating:
  - noise0 and noise1 are sampled in the step cycle and ignored otherwise.
  - budget = MAX_ERR - (sum of injected errors in the previous WIN-1 steps). History is a WIN-1-deep record of 2-bit counts that advances only on steps.
  - Grant noise0 if budget>=1. Grant noise1 if the remaining budget is >=1. noise0 has priority.
  - out1 = c0 ^ grant0; out2 = c1 ^ grant1.
  - noise_drop=1 (registered, aligned with the symbol) if any request was not granted.
- err_count adds grant0+grant1 per step and saturates at 255. It clears on the cycle after frame_done. The window history is NOT cleared between frames.
- Invariant: no WIN consecutive steps contain more than MAX_ERR flips.
- Back-to-back frames: in_valid held high gives FRAME_LEN accepts, then K-1 stall cycles, then the next frame starts immediately.

Test Plan:
1. Impulse, defaults, no noise: frame of in_bit 1 then fifteen 0s -> out1 = 1,1,0,1 then 0s; out2 = 1,1,1,1 then 0s; 19 out_valid symbols; frame_done on the 19th.
2. Tail/handshake: in_valid always 1 -> in_ready low for exactly 3 cycles after every 16 accepts; out_valid continuous.
3. Window budget (WIN=4, MAX_ERR=1), all-zero data: noise0=1 on every step -> flips on steps 0, 4, 8, ...; noise_drop on steps 1-3, 5-7, ...
4. Dual request with MAX_ERR=2, quiet history: noise0=noise1=1 on one step -> out1=out2=1 and err_count += 2. An immediate repeat of both -> both dropped.
5. Reset mid-frame: assert rst_n=0 after 7 accepts -> all outputs 0 asynchronously; after release, a new frame of 16 bits is accepted with no stale tail or memory.
6. Parameter sweep: K=3, G0=3'b111, G1=3'b101 -> impulse gives out1 = 1,1,1 and out2 = 1,0,1; tail length 2.
